voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Schedules the eight PWM tone generators as a shared voice pool.
- Accepts note-on/note-off events from the core over a valid/ready handshake.
- Picks a voice: retrigger of the same note, else the lowest free voice, else steals the least-recently-allocated voice.
- Drives each voice's 16-bit period register that feeds its pwm instance.

Parameters:
NUM_VOICES, 8, number of voices / pwm channels (power of two, 2..16)
NOTE_W, 7, note number width (MIDI range)
REG_W, 16, pwm period register width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ev_valid  in  1  event request
ev_ready  out  1  allocator can accept an event
ev_on  in  1  1 = note-on, 0 = note-off
ev_note  in  NOTE_W  note number
ev_period  in  REG_W  pwm period for the note (note-on only)
all_off  in  1  silence all voices
pwm_regs  out  NUM_VOICES*REG_W  voice i period at bits [i*REG_W +: REG_W]
voice_busy  out  NUM_VOICES  voice i holds a note
steal  out  1  one-cycle pulse: the last note-on stole a busy voice
active_count  out  $clog2(NUM_VOICES)+1  number of busy voices

Behaviour:
- Reset (async, any time, including mid-event):
  - pwm_regs = 0, voice_busy = 0, steal = 0, active_count = 0.
  - Per-voice notes = 0; LRU rank of voice i = i; state = IDLE; the latched event is discarded.
- States:
  - IDLE: ev_ready = !all_off.
  - APPLY: ev_ready = 0.
- Handshake and throughput:
  - Event accepted at a clk edge where ev_valid && ev_ready. Inputs are latched and state moves to APPLY.
  - The next edge commits the result and returns to IDLE.
  - Maximum throughput is one event per 2 cycles.
  - Results are visible 2 edges after acceptance.
- Note-on voice selection (evaluated in APPLY on the latched event):
  1. A busy voice with note == ev_note (lowest index if several): retrigger, period overwritten.
  2. Else the lowest-index non-busy voice.
  3. Else the voice with rank NUM_VOICES-1 (oldest); steal = 1 for exactly the commit cycle.
- Note-on commit:
  - Chosen voice gets busy = 1, note = ev_note, reg = ev_period.
  - LRU update with r = old rank of the chosen voice: every voice with rank < r gets rank+1; the chosen voice gets rank 0. Ranks always remain a permutation of 0..NUM_VOICES-1.
- Note-on with ev_period == 0 is handled exactly as a note-off for ev_note.
- Note-off:
  - Every busy voice with matching note gets busy = 0 and reg = 0. Ranks are unchanged.
  - No match: no-op, still takes 2 cycles.
- steal is 0 on every commit except a stealing note-on.
- all_off:
  - Sampled only in IDLE. Takes priority over ev_valid in the same cycle; the event is not accepted.
  - Next edge: all busy = 0, all regs = 0. Ranks and notes are unchanged. State stays IDLE.
  - all_off asserted during APPLY is ignored for that cycle; the pending event commits normally.
- active_count is a registered popcount of voice_busy, updated in the same cycle as voice_busy.
- A period of 0 means silence to the pwm block. The allocator never writes a nonzero period to a non-busy voice.

Decomposition:
- synth_pkg holds:
  - NUM_VOICES, NOTE_W, REG_W defaults.
  - State encoding IDLE/APPLY.
  - RANK_W = $clog2(NUM_VOICES).
- One sub-module, voice_lru_rank:
  - Holds the rank array.
  - Outputs the oldest-voice index.
  - Performs the promote-to-0 update on an alloc strobe plus voice index.
- Selection priority encoders and the register file stay in voice_allocator.

Test Plan:
- Reset then note-on note 60 period 0x1234 → voice 0 busy, pwm_regs[15:0]=0x1234, active_count=1, ev_ready low exactly 1 cycle after accept.
- 8 note-ons, notes 60..67 → voices 0..7 busy, steal never pulses. 9th note-on, note 70 period 0x0500 → steal pulses 1 cycle; voice 0 (oldest) gets note 70; active_count stays 8.
- Continuing from the previous scenario, note-on note 61 with a new period 0x0777 → retrigger of voice 1 (no steal); voice 1 becomes rank 0; the next steal takes voice 2.
- Note-off note 63 → voice 3 busy=0, reg=0. Next note-on note 80 → lands in voice 3. Note-off for an unplayed note 99 → no change, ready returns after 2 cycles.
- all_off and ev_valid in the same IDLE cycle → event not accepted, all regs 0, active_count 0. The event is accepted the following cycle.
- Reset asserted mid-APPLY (asynchronously, between edges) → outputs clear immediately without waiting for a clk edge; the pending event never commits; ev_ready = 1 after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared defaults and encodings for the voice allocator slice.
package synth_pkg;
   localparam int unsigned NUM_VOICES = 8;
   localparam int unsigned NOTE_W     = 7;
   localparam int unsigned REG_W      = 16;
   localparam int unsigned RANK_W     = $clog2(NUM_VOICES);

   typedef enum logic {
      IDLE  = 1'b0,
      APPLY = 1'b1
   } state_t;
endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake between the core (master) and the voice allocator (slave).
interface voice_allocator_if #(
   parameter int unsigned NOTE_W = synth_pkg::NOTE_W,
   parameter int unsigned REG_W  = synth_pkg::REG_W
);
   logic              ev_valid;
   logic              ev_ready;
   logic              ev_on;
   logic [NOTE_W-1:0] ev_note;
   logic [REG_W-1:0]  ev_period;

   modport master (output ev_valid, ev_on, ev_note, ev_period, input ev_ready);
   modport slave  (input ev_valid, ev_on, ev_note, ev_period, output ev_ready);
endinterface

// File: rtl/voice_lru_rank.sv
// Allocation-age ranks per voice: 0 = most recent, NUM_VOICES-1 = oldest.
module voice_lru_rank #(
   parameter int unsigned NUM_VOICES = synth_pkg::NUM_VOICES,
   localparam int unsigned RANK_W = $clog2(NUM_VOICES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc,
   input  logic [RANK_W-1:0] alloc_idx,
   output logic [RANK_W-1:0] oldest
);
   logic [RANK_W-1:0] rank [NUM_VOICES];

   // Promote the allocated voice to 0, age every voice that was younger than it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_VOICES; i++) rank[i] <= RANK_W'(i);
      end else if (alloc) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (RANK_W'(i) == alloc_idx)
               rank[i] <= '0;
            else if (rank[i] < rank[alloc_idx])
               rank[i] <= rank[i] + RANK_W'(1);
         end
      end
   end

   always_comb begin
      oldest = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         if (rank[i] == RANK_W'(NUM_VOICES - 1)) oldest = RANK_W'(i);
   end
endmodule

// File: rtl/voice_allocator.sv
// Shares the pwm tone generators as a voice pool: retrigger, lowest free, else steal oldest.
module voice_allocator #(
   parameter int unsigned NUM_VOICES = synth_pkg::NUM_VOICES,
   parameter int unsigned NOTE_W     = synth_pkg::NOTE_W,
   parameter int unsigned REG_W      = synth_pkg::REG_W,
   localparam int unsigned RANK_W = $clog2(NUM_VOICES),
   localparam int unsigned CNT_W  = RANK_W + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   voice_allocator_if.slave            ev,
   input  logic                        all_off,
   output logic [NUM_VOICES*REG_W-1:0] pwm_regs,
   output logic [NUM_VOICES-1:0]       voice_busy,
   output logic                        steal,
   output logic [CNT_W-1:0]            active_count
);
   import synth_pkg::*;

   state_t            state, state_nxt;
   logic              accept, apply, do_on, steal_c;
   logic              lat_on;
   logic [NOTE_W-1:0] lat_note;
   logic [REG_W-1:0]  lat_period;

   logic [NOTE_W-1:0] notes     [NUM_VOICES];
   logic [NOTE_W-1:0] notes_nxt [NUM_VOICES];
   logic [REG_W-1:0]  regs      [NUM_VOICES];
   logic [REG_W-1:0]  regs_nxt  [NUM_VOICES];
   logic [NUM_VOICES-1:0] busy_nxt, match;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              hit, any_free;
   logic [RANK_W-1:0] hit_idx, free_idx, oldest, chosen;

   assign accept = ev.ev_valid && ev.ev_ready;
   assign apply  = (state == APPLY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = APPLY;
         APPLY:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // all_off wins over a pending request in IDLE
   always_comb begin
      ev.ev_ready = 1'b0;
      if (state == IDLE) ev.ev_ready = !all_off;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_on     <= 1'b0;
         lat_note   <= '0;
         lat_period <= '0;
      end else if (accept) begin
         lat_on     <= ev.ev_on;
         lat_note   <= ev.ev_note;
         lat_period <= ev.ev_period;
      end
   end

   // Descending scan so the lowest matching/free index wins
   always_comb begin
      match    = '0;
      hit      = 1'b0;
      hit_idx  = '0;
      any_free = 1'b0;
      free_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (voice_busy[i] && notes[i] == lat_note) begin
            match[i] = 1'b1;
            hit      = 1'b1;
            hit_idx  = RANK_W'(i);
         end
         if (!voice_busy[i]) begin
            any_free = 1'b1;
            free_idx = RANK_W'(i);
         end
      end
   end

   // A zero period is treated as a note-off
   assign do_on   = apply && lat_on && (lat_period != '0);
   assign chosen  = hit ? hit_idx : (any_free ? free_idx : oldest);
   assign steal_c = do_on && !hit && !any_free;

   voice_lru_rank #(.NUM_VOICES(NUM_VOICES)) u_lru (
      .clk       (clk),
      .reset     (reset),
      .alloc     (do_on),
      .alloc_idx (chosen),
      .oldest    (oldest)
   );

   always_comb begin
      busy_nxt  = voice_busy;
      regs_nxt  = regs;
      notes_nxt = notes;
      if (state == IDLE && all_off) begin
         busy_nxt = '0;
         for (int i = 0; i < NUM_VOICES; i++) regs_nxt[i] = '0;
      end else if (do_on) begin
         busy_nxt[chosen]  = 1'b1;
         regs_nxt[chosen]  = lat_period;
         notes_nxt[chosen] = lat_note;
      end else if (apply) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (match[i]) begin
               busy_nxt[i] = 1'b0;
               regs_nxt[i] = '0;
            end
         end
      end
      cnt_nxt = '0;
      for (int i = 0; i < NUM_VOICES; i++) cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         voice_busy   <= '0;
         active_count <= '0;
         steal        <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            regs[i]  <= '0;
            notes[i] <= '0;
         end
      end else begin
         voice_busy   <= busy_nxt;
         active_count <= cnt_nxt;
         steal        <= steal_c;
         regs         <= regs_nxt;
         notes        <= notes_nxt;
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pwm
      assign pwm_regs[g*REG_W +: REG_W] = regs[g];
   end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed scoreboard bench for voice_allocator: expected commits queued, monitor compares.
module tb_voice_allocator;
   logic         clk;
   logic         reset;
   logic         all_off;
   logic [127:0] pwm_regs;
   logic [7:0]   voice_busy;
   logic         steal;
   logic [3:0]   active_count;

   voice_allocator_if #(.NOTE_W(7), .REG_W(16)) ev_if ();

   voice_allocator dut (
      .clk          (clk),
      .reset        (reset),
      .ev           (ev_if),
      .all_off      (all_off),
      .pwm_regs     (pwm_regs),
      .voice_busy   (voice_busy),
      .steal        (steal),
      .active_count (active_count)
   );

   typedef struct {
      string      name;
      logic [7:0] busy;
      int         v;
      logic [15:0] rv;
      logic       st;
      logic [3:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   countdown = 0;
   bit   sc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic push_exp(input string nm, input logic [7:0] b, input int v,
                           input logic [15:0] rv, input logic st, input logic [3:0] c);
      exp_t e;
      e.name = nm; e.busy = b; e.v = v; e.rv = rv; e.st = st; e.cnt = c;
      q.push_back(e);
   endtask

   // Called just after an active edge; returns at the negedge after the commit edge
   task automatic send(input logic on, input logic [6:0] note, input logic [15:0] per, input bit aoff);
      bit ok = 0;
      ev_if.ev_valid = 1'b1; ev_if.ev_on = on; ev_if.ev_note = note; ev_if.ev_period = per;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (ev_if.ev_ready) ok = 1;
         else begin @(posedge clk); #1; end
      end
      if (!ok) begin
         chk("accept_timeout", 128'(ev_if.ev_ready), 128'd1);
         ev_if.ev_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      ev_if.ev_valid = 1'b0;
      if (aoff) all_off = 1'b1;
      @(negedge clk);
      chk("ready_low_apply", 128'(ev_if.ev_ready), 128'd0);
      @(posedge clk); #1;
      all_off = 1'b0;
      @(negedge clk);
      chk("ready_back", 128'(ev_if.ev_ready), 128'd1);
   endtask

   task automatic issue(input logic on, input logic [6:0] note, input logic [15:0] per, input bit aoff);
      @(posedge clk); #1;
      send(on, note, per, aoff);
   endtask

   // Monitor: a commit lands on the second edge after an accept
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            countdown = 0;
            sc = 0;
         end else begin
            if (sc) begin
               chk("steal_clear", 128'(steal), 128'd0);
               sc = 0;
            end
            if (countdown == 1) begin
               if (q.size() == 0) begin
                  chk("sb_unexpected_commit", 128'(q.size()), 128'd1);
               end else begin
                  e = q.pop_front();
                  chk({e.name, "_busy"},  128'(voice_busy), 128'(e.busy));
                  chk({e.name, "_reg"},   128'(pwm_regs[e.v*16 +: 16]), 128'(e.rv));
                  chk({e.name, "_steal"}, 128'(steal), 128'(e.st));
                  chk({e.name, "_count"}, 128'(active_count), 128'(e.cnt));
               end
               sc = 1;
            end
            if (countdown > 0) countdown--;
            if (ev_if.ev_valid && ev_if.ev_ready) countdown = 2;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; all_off = 1'b0;
      ev_if.ev_valid = 1'b0; ev_if.ev_on = 1'b0; ev_if.ev_note = '0; ev_if.ev_period = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy",  128'(voice_busy), 128'd0);
      chk("rst_regs",  pwm_regs, 128'd0);
      chk("rst_steal", 128'(steal), 128'd0);
      chk("rst_count", 128'(active_count), 128'd0);
      chk("rst_ready", 128'(ev_if.ev_ready), 128'd1);

      push_exp("on60", 8'h01, 0, 16'h1234, 1'b0, 4'd1);
      issue(1'b1, 7'd60, 16'h1234, 1'b0);
      for (int k = 1; k < 8; k++) begin
         push_exp("fill", 8'((1 << (k + 1)) - 1), k, 16'h1000 + 16'(k), 1'b0, 4'(k + 1));
         issue(1'b1, 7'(60 + k), 16'h1000 + 16'(k), 1'b0);
      end
      push_exp("steal70",  8'hFF, 0, 16'h0500, 1'b1, 4'd8);
      issue(1'b1, 7'd70, 16'h0500, 1'b0);
      push_exp("retrig61", 8'hFF, 1, 16'h0777, 1'b0, 4'd8);
      issue(1'b1, 7'd61, 16'h0777, 1'b0);
      push_exp("steal90",  8'hFF, 2, 16'h0900, 1'b1, 4'd8);
      issue(1'b1, 7'd90, 16'h0900, 1'b0);
      push_exp("off63",    8'hF7, 3, 16'h0000, 1'b0, 4'd7);
      issue(1'b0, 7'd63, 16'h0000, 1'b0);
      push_exp("on80",     8'hFF, 3, 16'h0800, 1'b0, 4'd8);
      issue(1'b1, 7'd80, 16'h0800, 1'b0);
      push_exp("off99",    8'hFF, 3, 16'h0800, 1'b0, 4'd8);
      issue(1'b0, 7'd99, 16'h0000, 1'b0);
      push_exp("on64p0",   8'hEF, 4, 16'h0000, 1'b0, 4'd7);
      issue(1'b1, 7'd64, 16'h0000, 1'b0);

      // all_off collides with a request: request must wait one cycle
      push_exp("after_alloff", 8'h01, 0, 16'h0321, 1'b0, 4'd1);
      @(posedge clk); #1;
      all_off = 1'b1;
      ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b1; ev_if.ev_note = 7'd50; ev_if.ev_period = 16'h0321;
      @(negedge clk);
      chk("alloff_ready", 128'(ev_if.ev_ready), 128'd0);
      @(posedge clk); #1;
      all_off = 1'b0;
      @(negedge clk);
      chk("alloff_busy",  128'(voice_busy), 128'd0);
      chk("alloff_regs",  pwm_regs, 128'd0);
      chk("alloff_count", 128'(active_count), 128'd0);
      send(1'b1, 7'd50, 16'h0321, 1'b0);

      push_exp("aoff_apply", 8'h03, 1, 16'h0456, 1'b0, 4'd2);
      issue(1'b1, 7'd51, 16'h0456, 1'b1);

      // Asynchronous reset while an event sits in APPLY
      @(posedge clk); #1;
      ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b1; ev_if.ev_note = 7'd52; ev_if.ev_period = 16'h0999;
      @(posedge clk); #1;
      ev_if.ev_valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("async_rst_busy",  128'(voice_busy), 128'd0);
      chk("async_rst_regs",  pwm_regs, 128'd0);
      chk("async_rst_count", 128'(active_count), 128'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 128'(ev_if.ev_ready), 128'd1);
      @(negedge clk);
      chk("post_rst_busy",  128'(voice_busy), 128'd0);
      chk("post_rst_regs",  pwm_regs, 128'd0);

      for (int k = 0; k < 10 && countdown != 0; k++) @(negedge clk);
      chk("sb_drain", 128'(q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
